// File: rtl/fifo_uart_pkg.sv
// Shared encodings and constants for the FIFO-to-UART drain.
// State values are fixed so debug dumps decode the same in either build.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 104;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: loads BAUD_DIV-1 on restart, counts down and holds at zero.
// tick is high at zero; tick_next flags the cycle before, for registered end-of-bit outputs.
module baud_tick_gen #(
    parameter int BAUD_DIV = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick,
    output logic tick_next
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LOAD = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign tick      = (r_cnt == '0);
    assign tick_next = (r_cnt == CW'(1));

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops one byte per frame from a FWFT FIFO and sends it as 8N1 UART; first start-bit cycle follows the capture edge.
// Back-pressure is by not popping; define FIFO_UART_DRAIN_PARITY_EN to add an even-parity bit (8E1).
module fifo_uart_drain
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_BITS,
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] rd_DATA,
    input  logic                  rd_empty,
    output logic                  rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [2:0]            r_bit_idx, w_bit_idx_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_tx_done, w_tx_done_nxt;
    logic                  w_restart, w_tick, w_tick_next;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    logic                  r_parity, w_parity_nxt;
`endif

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk       (clk),
        .rst       (rst),
        .restart   (w_restart),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_rd_en   <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
`ifdef FIFO_UART_DRAIN_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_tx_done <= w_tx_done_nxt;
`ifdef FIFO_UART_DRAIN_PARITY_EN
            r_parity  <= w_parity_nxt;
`endif
        end
    end

    // Outputs are registered, so tx is computed for the state being entered.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_idx_nxt = r_bit_idx;
        w_rd_en_nxt   = 1'b0;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_tx_done_nxt = 1'b0;
        w_restart     = 1'b0;
`ifdef FIFO_UART_DRAIN_PARITY_EN
        w_parity_nxt  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (en && !rd_empty) begin
                    w_state_nxt = ST_START;
                    w_shreg_nxt = rd_DATA;
                    w_rd_en_nxt = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_restart   = 1'b1;
`ifdef FIFO_UART_DRAIN_PARITY_EN
                    w_parity_nxt = ^rd_DATA;
`endif
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_idx_nxt = '0;
                    w_tx_nxt      = r_shreg[0];
                    w_restart     = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_restart     = 1'b1;
                    w_shreg_nxt   = r_shreg >> 1;
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    w_tx_nxt      = r_shreg[1];
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef FIFO_UART_DRAIN_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_tx_nxt    = r_parity;
`else
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end
                end
            end
`ifdef FIFO_UART_DRAIN_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                    w_restart   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                // Raised one cycle early so the registered pulse lands on the last stop cycle.
                w_tx_done_nxt = w_tick_next;
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign rd_en   = r_rd_en;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at BAUD_DIV=4 with a small FWFT FIFO model.
// Frame bits are sampled mid-bit and compared with hand-built 8N1 / 8E1 patterns.
module tb_fifo_uart_drain;

    localparam int BD = 4;
`ifdef FIFO_UART_DRAIN_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       rd_en, tx, busy, tx_done;
    logic       rd_empty;
    logic [7:0] rd_DATA;

    logic [7:0] mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         total  = 0;
    int         bad    = 0;

    always #5 clk = ~clk;

    assign rd_empty = (rd_ptr == wr_ptr);
    assign rd_DATA  = mem[rd_ptr & 15];

    // The pop lands just after the edge that sampled rd_en high.
    always @(posedge clk) begin
        if (rd_en) begin
            #1;
            if (rd_ptr != wr_ptr) rd_ptr = rd_ptr + 1;
        end
    end

    fifo_uart_drain #(.DATA_WIDTH(8), .BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rd_DATA  (rd_DATA),
        .rd_empty (rd_empty),
        .rd_en    (rd_en),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr & 15] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_pop(input string tag, output int steps, output int lows, output bit ok);
        steps = 0;
        lows  = 0;
        ok    = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            steps++;
            if (rd_en) begin
                ok = 1'b1;
                break;
            end
            if (!busy) lows++;
        end
        if (!ok) chk({tag, " pop timeout"}, 32'd0, 32'd1);
    endtask

    // Entered at the negedge of the first START cycle (rd_en high).
    task automatic run_frame(input logic [7:0] b, input string tag, input int drop_at);
        logic [10:0] obs, exp;
        int done_at, ndone, nlow, extra;
        obs = '0; done_at = 0; ndone = 0; nlow = 0; extra = 0;
        for (int c = 1; c <= FRAME; c++) begin
            if (c > 1) @(negedge clk);
            if (c == drop_at) en = 1'b0;
            if ((c - 1) % BD == 1) obs[(c - 1) / BD] = tx;
            if (tx_done) begin
                ndone++;
                done_at = c;
            end
            if (!busy) nlow++;
            if (rd_en && c != 1) extra++;
        end
        exp      = '0;
        exp[8:1] = b;
`ifdef FIFO_UART_DRAIN_PARITY_EN
        exp[9]   = ^b;
        exp[10]  = 1'b1;
`else
        exp[9]   = 1'b1;
`endif
        chk({tag, " frame bits"}, 32'(obs), 32'(exp));
        chk({tag, " tx_done cycle"}, done_at, FRAME);
        chk({tag, " tx_done pulses"}, ndone, 1);
        chk({tag, " busy low in frame"}, nlow, 0);
        chk({tag, " extra rd_en"}, extra, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  steps, lows, ntx, npop;
        bit  ok;

        repeat (3) @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset rd_en", rd_en, 0);
        chk("reset busy", busy, 0);
        chk("reset tx_done", tx_done, 0);

        rst = 1'b1;
        en  = 1'b1;
        ntx = 0; npop = 0;
        repeat (100) @(negedge clk) begin
            if (!tx) ntx++;
            if (rd_en) npop++;
        end
        chk("empty rd_en count", npop, 0);
        chk("empty tx low count", ntx, 0);

        push(8'hA5);
        wait_pop("a5", steps, lows, ok);
        if (ok) run_frame(8'hA5, "a5", 0);
        @(negedge clk);
        chk("a5 idle busy", busy, 0);
        chk("a5 idle tx", tx, 1);

        push(8'h00); push(8'hFF); push(8'h3C);
        wait_pop("b2b00", steps, lows, ok);
        if (ok) run_frame(8'h00, "b2b00", 0);
        wait_pop("b2bff", steps, lows, ok);
        chk("b2bff pop spacing", steps, 2);
        chk("b2bff busy low cycles", lows, 1);
        if (ok) run_frame(8'hFF, "b2bff", 0);
        wait_pop("b2b3c", steps, lows, ok);
        chk("b2b3c pop spacing", steps, 2);
        chk("b2b3c busy low cycles", lows, 1);
        if (ok) run_frame(8'h3C, "b2b3c", 0);

        push(8'h55); push(8'h77);
        wait_pop("en55", steps, lows, ok);
        if (ok) run_frame(8'h55, "en55", 20);
        npop = 0;
        repeat (60) @(negedge clk) if (rd_en) npop++;
        chk("en low rd_en count", npop, 0);
        chk("en low fifo level", wr_ptr - rd_ptr, 1);
        en = 1'b1;
        wait_pop("en77", steps, lows, ok);
        if (ok) run_frame(8'h77, "en77", 0);

        push(8'h81); push(8'h42);
        wait_pop("rst81", steps, lows, ok);
        repeat (17) @(negedge clk);
        chk("rst81 data bit3", tx, 0);
        rst = 1'b0;
        #1;
        chk("midrst tx", tx, 1);
        chk("midrst busy", busy, 0);
        chk("midrst rd_en", rd_en, 0);
        chk("midrst state", 32'(dut.r_state), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_pop("rst42", steps, lows, ok);
        if (ok) run_frame(8'h42, "rst42", 0);

`ifdef FIFO_UART_DRAIN_PARITY_EN
        push(8'h07); push(8'h03);
        wait_pop("par07", steps, lows, ok);
        if (ok) run_frame(8'h07, "par07", 0);
        wait_pop("par03", steps, lows, ok);
        if (ok) run_frame(8'h03, "par03", 0);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Drains a synchronous BRAM FIFO and serialises each byte onto a UART TX line (8 data bits, LSB first, 1 stop bit). It sits on the read side of the sniffer capture FIFO and consumes its read-port signals `rd_en`, `rd_DATA` and `rd_empty`, forwarding captured USB traffic to the host through the FTDI UART. It pops one byte per frame with a single-cycle `rd_en` pulse and back-pressures the FIFO simply by not popping.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: FIFO word width. Only 8 is supported.
- `BAUD_DIV`, 104: clock cycles per UART bit (12 MHz / 115200). Minimum 2.

**Ports**
- `clk`  in  1  reference clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  drain enable. When low, no new frame starts; a frame in progress always completes.
- `rd_DATA`  in  8  FIFO head word. Valid whenever `rd_empty` is low (first-word-fall-through contract).
- `rd_empty`  in  1  FIFO empty flag.
- `rd_en`  out  1  FIFO pop, registered, one-cycle pulse.
- `tx`  out  1  UART line, idle high.
- `busy`  out  1  high while a frame is in progress.
- `tx_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation

**States:** IDLE, START, DATA, PARITY (only with the macro), STOP.

- **IDLE**
  - `tx`=1, `busy`=0.
  - If `en` and `!rd_empty` at a posedge: latch `rd_DATA` into the shift register, set `rd_en`=1 for the next cycle, go to START, load the baud counter.
- **START**
  - `tx`=0 for `BAUD_DIV` cycles, then go to DATA with bit index 0.
- **DATA**
  - `tx` = shift register LSB.
  - Every `BAUD_DIV` cycles: shift right and increment the bit index.
  - After bit 7, go to PARITY if it is compiled in, else STOP.
- **STOP**
  - `tx`=1 for `BAUD_DIV` cycles.
  - `tx_done` pulses on the final cycle, then go to IDLE.

**Counters**
- Baud counter width is `$clog2(BAUD_DIV)`. It loads `BAUD_DIV-1`, decrements, and a tick occurs at 0.
- Bit index is 3 bits.

**Boundary conditions**
- **FIFO empty in IDLE:** remain in IDLE with `tx`=1 and no `rd_en`.
- **`en` falling mid-frame:** the frame finishes and the next frame does not start.
- **Back-to-back frames:** IDLE lasts exactly 1 cycle between frames when the FIFO is non-empty.
- **Writer push during the pop cycle:** has no effect on the latched byte. The pop and the push are independent FIFO operations.
- **Reset, including mid-frame:**
  - State goes to IDLE, `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0, counters=0.
  - A byte already popped is lost.
- **`rd_en` and emptiness:** `rd_en` is never asserted while `rd_empty` was high at the capture edge.

## Timing

- **Latency to start bit:** capture edge T → `rd_en`=1 and `tx`=0 during cycle T+1. The FIFO pop takes effect at the end of T+1.
- **Frame length:** 10·`BAUD_DIV` cycles (11·`BAUD_DIV` with parity) from the first START cycle to the last STOP cycle.
- **Throughput:** one byte every 10·`BAUD_DIV`+1 cycles when the FIFO stays non-empty.
- **Outputs:** all outputs are registered. `busy` rises with START and falls on entry to IDLE.

## Configuration

- `FIFO_UART_DRAIN_PARITY_EN`
  - **Defined:** a PARITY state is inserted after DATA. It drives the even-parity bit (XOR of the 8 data bits) for `BAUD_DIV` cycles, and the frame is 11 bits.
  - **Undefined:** the PARITY state and its logic are absent, and the frame is 10 bits.

## Structure

- **Shared package `fifo_uart_pkg`:**
  - state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - UART constants (DATA_BITS=8, default BAUD_DIV=104).
- **Sub-module `baud_tick_gen`:**
  - load/decrement counter with `BAUD_DIV` parameter;
  - input `restart`, output `tick`.
- **Top level:** FSM, shift register, bit index, and output registers.

## Test plan

All scenarios use `BAUD_DIV`=4.

1. Reset → `tx`=1, `rd_en`=0, `busy`=0, `tx_done`=0; with `rd_empty`=1 and `en`=1 for 100 cycles → no `rd_en`, `tx` stays 1.
2. FIFO holding 0xA5, `en`=1 → `rd_en` pulses once. `tx` sequence, 4 cycles per bit: 0, then 1,0,1,0,0,1,0,1, then 1. `tx_done` pulses at cycle 40 after `rd_en`.
3. FIFO holding 0x00, 0xFF, 0x3C back-to-back → three `rd_en` pulses spaced 41 cycles apart, frames decoded correctly, `busy` low for exactly 1 cycle between frames.
4. `en` dropped in the middle of the 0x55 data bits → frame completes, no further `rd_en` until `en` rises again, then the next byte drains.
5. `rst` asserted at data bit 3 of 0x81 → `tx`=1 immediately, state IDLE. After release, the next FIFO byte (not 0x81) is transmitted.
6. With `FIFO_UART_DRAIN_PARITY_EN`, byte 0x07 → parity bit 1, frame is 44 cycles. Byte 0x03 → parity bit 0.
